// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX hazard inputs plus pipeline controls.
// master drives the pipeline inputs, slave (the controller) drives controls and counters.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             IFID_UsesRt;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_Rt;
    logic             BranchTaken;
    logic             MulIssue;
    logic             CntClear;
    logic             PCWrite;
    logic             IFID_Stall;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    logic [1:0]       State;

    modport master (
        output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
        output BranchTaken, MulIssue, CntClear,
        input  PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble,
        input  StallCount, FlushCount, State
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
        input  BranchTaken, MulIssue, CntClear,
        output PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble,
        output StallCount, FlushCount, State
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, mul/div wait.
// Ports: Clk, Reset (async active-low), bus (hazard_ctrl_if.slave).
module hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1
    } state_e;

    localparam int WAIT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MUL_LATENCY - 2);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic lu;
    logic pc_write, ifid_stall, ifid_flush, idex_bubble;

    assign lu = bus.IDEX_MemRead && (bus.IDEX_Rt != 5'd0) &&
                ((bus.IDEX_Rt == bus.IFID_Rs) ||
                 (bus.IFID_UsesRt && (bus.IDEX_Rt == bus.IFID_Rt)));

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pc_write    = 1'b1;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.BranchTaken) begin
                    // Wrong-path hazards and issues are dropped with the flush.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (bus.MulIssue) begin
                    // The op itself advances this cycle; stalls start next cycle.
                    state_d = MUL_WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            MUL_WAIT: begin
                pc_write    = 1'b0;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                if (wait_q == '0) begin
                    state_d = RUN;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
        // Reset overrides everything so the pipeline fills with bubbles.
        if (!Reset) begin
            pc_write    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.CntClear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (ifid_stall && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (ifid_flush && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IFID_Stall  = ifid_stall;
    assign bus.IFID_Flush  = ifid_flush;
    assign bus.IDEX_Bubble = idex_bubble;
    assign bus.StallCount  = stall_cnt_q;
    assign bus.FlushCount  = flush_cnt_q;
    assign bus.State       = state_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the IF/ID register, PC write enable and ID/EX bubble insertion.
- Detects load-use hazards, redirects on taken branches, and stalls the front end for multi-cycle multiply/divide ops.
- Sits beside the decode stage and drives the Stall/Flush inputs of the IF/ID register and the bubble select of ID/EX.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- MUL_LATENCY, 4: total EX cycles of a multi-cycle op; must be >= 2. Front end stalls MUL_LATENCY-1 cycles.
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low; Reset==0 resets immediately.
- IFID_Rs  in  5  source reg 1 of instruction in ID.
- IFID_Rt  in  5  source reg 2 of instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads Rt.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  load destination register in EX.
- BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- MulIssue  in  1  ID holds a multi-cycle op ready to issue.
- CntClear  in  1  synchronous clear of both counters.
- PCWrite  out  1  PC update enable.
- IFID_Stall  out  1  hold IF/ID contents.
- IFID_Flush  out  1  zero IF/ID contents.
- IDEX_Bubble  out  1  load NOP into ID/EX.
- StallCount  out  CNT_W  cycles with IFID_Stall=1.
- FlushCount  out  CNT_W  cycles with IFID_Flush=1.
- State  out  2  0=RUN, 1=MUL_WAIT; 2 and 3 are illegal.

Behaviour:
Reset
- While Reset==0: State=RUN, wait counter=0, StallCount=0, FlushCount=0.
- Control outputs forced during reset: PCWrite=0, IFID_Stall=0, IFID_Flush=1, IDEX_Bubble=1.
- Reset asserted during MUL_WAIT aborts the wait; after release, State=RUN.

Control outputs
- Combinational from State and inputs; zero-latency, same-cycle response.
- Default in RUN with no event: PCWrite=1, IFID_Stall=0, IFID_Flush=0, IDEX_Bubble=0.

Load-use hazard (LU)
- LU = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & (IDEX_Rt==IFID_Rt))).

RUN priority: BranchTaken > LU > MulIssue
- BranchTaken: PCWrite=1, IFID_Flush=1, IDEX_Bubble=1, IFID_Stall=0. Stay in RUN. Any LU or MulIssue that cycle is discarded (wrong-path).
- LU: PCWrite=0, IFID_Stall=1, IDEX_Bubble=1. Stay in RUN. The hazard clears next cycle because ID/EX now holds a bubble, giving a one-cycle stall. MulIssue that cycle is ignored and re-evaluated next cycle.
- MulIssue: default outputs (the op advances into EX). Next State=MUL_WAIT, wait counter loaded with MUL_LATENCY-2.

MUL_WAIT
- Outputs: PCWrite=0, IFID_Stall=1, IDEX_Bubble=1, IFID_Flush=0.
- Each cycle: if counter==0, next State=RUN; else decrement.
- Result: exactly MUL_LATENCY-1 consecutive stall cycles.
- BranchTaken, LU and MulIssue are ignored in MUL_WAIT. BranchTaken there is a protocol violation; the bench flags it with an assertion.

Illegal state
- State 2 or 3 returns to RUN next cycle, with default outputs in the meantime.

Counters
- StallCount +1 on each posedge with IFID_Stall=1; saturates at 2^CNT_W-1, no wrap.
- FlushCount +1 on each posedge with IFID_Flush=1; saturates likewise.
- Counting applies only while Reset==1.
- CntClear=1 sets both counters to 0 at the next posedge; clear wins over a simultaneous increment.

Test Plan:
- Reset: hold Reset=0 for 3 cycles -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=0, counters 0, State=0. After release with idle inputs -> PCWrite=1, others 0.
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> PCWrite=0, IFID_Stall=1, IDEX_Bubble=1 that cycle, StallCount=1.
  - Same with IDEX_Rt=0, or with IFID_Rt=5 and IFID_UsesRt=0 -> no stall.
- Branch over hazard: BranchTaken=1 together with a valid LU and MulIssue=1 -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Stall=0, State stays 0, FlushCount +1.
- Multi-cycle op: MUL_LATENCY=4, MulIssue=1 for one cycle -> next 3 cycles State=1, IFID_Stall=1, PCWrite=0; 4th cycle State=0; StallCount=3.
- Reset mid-wait: assert Reset=0 on the 2nd MUL_WAIT cycle -> State=0 immediately, counters 0, no residual stall after release.
- Saturation/clear: CNT_W=4, hold LU true 20 cycles -> StallCount stops at 15. Then CntClear=1 with LU still true -> StallCount=0 next cycle.
